// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - Y86-style instruction encoder writing variable-length byte streams into a small instruction memory
// Optional feature: define ENC_CALLRET_EN to encode call (icode 8) and ret (icode 9).
module instr_encoder #(
  parameter  int MEM_BYTES = 1024,
  localparam int AW        = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    icode,
  input  logic [3:0]    ifun,
  input  logic [3:0]    rA,
  input  logic [3:0]    rB,
  input  logic [63:0]   valC,
  output logic [AW-1:0] wr_ptr,
  output logic          done,
  output logic          err,
  input  logic [AW-1:0] rd_addr,
  output logic [79:0]   rd_instr
);

  typedef enum logic {ST_IDLE, ST_WRITE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_mem [MEM_BYTES];
  logic [3:0]    r_cnt;
  logic [3:0]    r_len;
  logic [3:0]    r_icode;
  logic [3:0]    r_ifun;
  logic [3:0]    r_ra;
  logic [3:0]    r_rb;
  logic [63:0]   r_valc;
  logic          r_clr_pend;
  logic [AW-1:0] r_wr_ptr;
  logic          r_err;

  logic          w_accept;
  logic [3:0]    w_len;
  logic [AW:0]   w_end;
  logic          w_ovf;
  logic          w_bad;
  logic          w_last;
  logic [2:0]    w_vidx;
  logic [7:0]    w_wbyte;
  logic [AW-1:0] w_waddr;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:       instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB: instr_len = 4'd2;
      4'h7, 4'h8:             instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:       instr_len = 4'd10;
      default:                instr_len = 4'd0;
    endcase
  endfunction

  function automatic logic instr_ok(input logic [3:0] ic);
`ifdef ENC_CALLRET_EN
    instr_ok = (ic <= 4'hB);
`else
    instr_ok = (ic <= 4'h7) || (ic == 4'hA) || (ic == 4'hB);
`endif
  endfunction

  assign in_ready = (r_state == ST_IDLE) && !clr && !rst;
  assign w_accept = in_valid && in_ready;
  assign w_len    = instr_len(icode);
  assign w_end    = {1'b0, r_wr_ptr} + (AW+1)'(w_len);
  // Ending exactly at MEM_BYTES is legal; the pointer then wraps to 0.
  assign w_ovf    = w_end > (AW+1)'(MEM_BYTES);
  assign w_bad    = !instr_ok(icode) || w_ovf;
  assign w_last   = (r_state == ST_WRITE) && (r_cnt == r_len - 4'd1);
  assign done     = w_last;
  assign wr_ptr   = r_wr_ptr;
  assign err      = r_err;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept && !w_bad) w_state_nxt = ST_WRITE;
      ST_WRITE: if (w_last)             w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_len      <= 4'd0;
      r_icode    <= 4'd0;
      r_ifun     <= 4'd0;
      r_ra       <= 4'd0;
      r_rb       <= 4'd0;
      r_valc     <= 64'd0;
      r_clr_pend <= 1'b0;
      r_wr_ptr   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (clr)
        r_err <= 1'b0;
      else if (w_accept && w_bad)
        r_err <= 1'b1;
      if (w_accept && !w_bad) begin
        r_icode    <= icode;
        r_ifun     <= ifun;
        r_ra       <= rA;
        r_rb       <= rB;
        r_valc     <= valC;
        r_len      <= w_len;
        r_cnt      <= 4'd0;
        r_clr_pend <= 1'b0;
      end
      if (r_state == ST_WRITE) begin
        // A clear seen mid-instruction is deferred so the write addresses stay valid.
        if (clr) r_clr_pend <= 1'b1;
        if (w_last) begin
          r_cnt      <= 4'd0;
          r_clr_pend <= 1'b0;
          r_wr_ptr   <= (clr || r_clr_pend) ? '0 : r_wr_ptr + AW'(r_len);
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end else if (clr) begin
        r_wr_ptr <= '0;
      end
    end
  end

  always_comb begin
    w_vidx  = 3'd0;
    w_wbyte = 8'h00;
    if (r_cnt == 4'd0) begin
      w_wbyte = {r_icode, r_ifun};
    end else if (r_cnt == 4'd1 && r_len != 4'd9) begin
      w_wbyte = {r_ra, r_rb};
    end else begin
      w_vidx  = (r_len == 4'd10) ? 3'(r_cnt - 4'd2) : 3'(r_cnt - 4'd1);
      w_wbyte = 8'(r_valc >> {~w_vidx, 3'b000});
    end
  end

  assign w_waddr = r_wr_ptr + AW'(r_cnt);

  // Memory has no reset so an interrupted instruction keeps its written bytes.
  always_ff @(posedge clk) begin
    if (r_state == ST_WRITE)
      r_mem[w_waddr] <= w_wbyte;
  end

  always_comb begin
    rd_instr = '0;
    for (int k = 0; k < 10; k++) begin
      if (({4'b0000, rd_addr} + (AW+4)'(k)) < (AW+4)'(MEM_BYTES))
        rd_instr[79-8*k -: 8] = r_mem[rd_addr + AW'(k)];
    end
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, giving instruction memory size in bytes (power of two, minimum 16); AW = log2(MEM_BYTES).
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port clr  input  1  synchronous clear of wr_ptr and err.
REQ-005 SHALL have port in_valid  input  1  an instruction tuple is presented.
REQ-006 SHALL have port in_ready  output  1  the encoder can accept a tuple this cycle.
REQ-007 SHALL have ports icode, ifun, rA, rB  input  4 each  instruction fields.
REQ-008 SHALL have port valC  input  64  constant field.
REQ-009 SHALL have port wr_ptr  output  AW  next free byte address.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the last byte of an instruction is written.
REQ-011 SHALL have port err  output  1  sticky error flag.
REQ-012 SHALL have port rd_addr  input  AW  fetch-side byte address.
REQ-013 SHALL have port rd_instr  output  80  bytes rd_addr..rd_addr+9, with rd_addr at bits [79:72].

Function
REQ-014 SHALL use FSM states IDLE and WRITE; in_ready = 1 only in IDLE with clr low.
REQ-015 SHALL accept a tuple on in_valid && in_ready, latch all fields, compute length LEN, and enter WRITE with byte counter 0.
REQ-016 SHALL use LEN: icode 0,1,9 -> 1; icode 2,6,A,B -> 2; icode 7,8 -> 9; icode 3,4,5 -> 10.
REQ-017 SHALL use byte 0 = {icode,ifun}; for 2/10-byte formats byte 1 = {rA,rB}; 10-byte formats bytes 2..9 = valC MSB first; 9-byte formats bytes 1..8 = valC MSB first.
REQ-018 SHALL write exactly one byte per WRITE cycle, at address wr_ptr+counter.
REQ-019 SHALL, on the cycle writing byte LEN-1, pulse done, advance wr_ptr by LEN, and return to IDLE; an accepted tuple therefore takes LEN cycles in WRITE, with in_ready high again on the following cycle.
REQ-020 SHALL treat icode C..F as invalid: on acceptance set err, write nothing, leave wr_ptr unchanged, and stay in IDLE.
REQ-021 SHALL treat wr_ptr+LEN > MEM_BYTES as overflow: on acceptance set err, write nothing, leave wr_ptr unchanged, and stay in IDLE; wr_ptr+LEN == MEM_BYTES is legal and wraps wr_ptr to 0.
REQ-022 SHALL make rd_instr combinational from memory contents as of the last clock edge; bytes with address >= MEM_BYTES read as 0x00.
REQ-023 SHALL give clr priority over acceptance when both occur in the same cycle; clr in WRITE completes the current instruction, then zeroes wr_ptr instead of advancing it.
REQ-024 SHALL hold err once set until rst or clr.

Reset
REQ-025 SHALL, on rst, force state IDLE, wr_ptr 0, counter 0, done 0, err 0; in_ready is 1 once rst deasserts.
REQ-026 SHALL leave memory contents unaffected by rst; an instruction interrupted mid-write keeps the bytes already written, and done does not pulse for it.

Configuration
REQ-027 SHALL, when macro ENC_CALLRET_EN is defined, encode icode 8 (call, 9 bytes) and icode 9 (ret, 1 byte) per REQ-016/017.
REQ-028 SHALL, when ENC_CALLRET_EN is undefined, treat icode 8 and 9 as invalid per REQ-020.

Verification
REQ-029 SHALL cover: irmovq icode3 ifun0 rA=F rB=2 valC=0x100 at wr_ptr 0 -> rd_addr 0 gives rd_instr 0x30F20000000000000100; done pulses on the 10th WRITE cycle; wr_ptr = 10.
REQ-030 SHALL cover: OPq icode6 ifun0 rA=4 rB=2 at wr_ptr 10 -> bytes 0x60, 0x42 at addresses 10 and 11; wr_ptr = 12.
REQ-031 SHALL cover: icode 0xC presented -> err = 1, memory and wr_ptr unchanged, in_ready stays high; clr -> err = 0 and wr_ptr = 0.
REQ-032 SHALL cover, with MEM_BYTES = 16: irmovq (wr_ptr 10), then a second irmovq -> err = 1 and wr_ptr stays 10; then pushq icode A rA=3 rB=F -> wr_ptr 12, bytes 0xA0, 0x3F; a further 4-byte fill ending at 16 wraps wr_ptr to 0.
REQ-033 SHALL cover: call valC=0x80 with ENC_CALLRET_EN defined -> bytes 80 00 00 00 00 00 00 00 80, wr_ptr += 9; without the macro -> err = 1 and no write.
REQ-034 SHALL cover: rst asserted during the 5th byte of an irmovq -> immediate IDLE, wr_ptr = 0, done never pulses, bytes 0..3 retain the values already written.
